// File: rtl/yrv_bus_arb_pkg.sv
// Shared definitions for the yrv bus arbiter: bus transfer encodings,
// arbiter state encodings and default starvation-counter configuration.
package yrv_bus_arb_pkg;

  // mem_trans / cpu_trans encodings; both 10 and 11 are data transfers
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_FETCH  = 2'b01,
    TRANS_DATA   = 2'b10,
    TRANS_DATA_X = 2'b11
  } mem_trans_t;

  // DMA_ADDR is only ever a combinational phase (the steal cycle); the
  // state register itself holds CPU_OWN or DMA_DATA
  typedef enum logic [1:0] {
    CPU_OWN  = 2'b00,
    DMA_ADDR = 2'b01,
    DMA_DATA = 2'b10
  } arb_state_t;

  localparam int unsigned ARB_WAIT_W   = 4;
  localparam int unsigned ARB_WAIT_MAX = 8;

endpackage

// File: rtl/yrv_bus_arb_wdog.sv
// yrv_arb_wdog: saturating starvation counter for the bus arbiter.
// Counts while inc is high, clears on clr, sat flags the WAIT_MAX value.
module yrv_arb_wdog
  import yrv_bus_arb_pkg::*;
#(
  parameter int unsigned WAIT_W   = ARB_WAIT_W,
  parameter int unsigned WAIT_MAX = ARB_WAIT_MAX
) (
  input  logic clk,
  input  logic resetb,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_MAX[WAIT_W-1:0];

  logic [WAIT_W-1:0] cnt;

  // clear has priority; count up and hold at CNT_MAX
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)                    cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/yrv_bus_arb.sv
// yrv_bus_arb: cycle-stealing arbiter between the yrv_cpu memory port and a
// secondary master. The cpu keeps priority; a secondary transfer steals one
// address-phase slot, the cpu's completing read data is parked in hold_reg
// and replayed in the following data phase.
// Build option: YRV_ARB_FAIR_EN adds the starvation counter (forced steals).
module yrv_bus_arb
  import yrv_bus_arb_pkg::*;
#(
  parameter int unsigned WAIT_W   = ARB_WAIT_W,
  parameter int unsigned WAIT_MAX = ARB_WAIT_MAX
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_trans,
  input  logic        cpu_write,
  input  logic        cpu_lock,
  input  logic [3:0]  cpu_ble,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic        dma_write,
  input  logic [3:0]  dma_ble,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_trans,
  output logic        mem_write,
  output logic        mem_lock,
  output logic [3:0]  mem_ble,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  arb_state_t  state, state_nxt, phase;
  logic        steal;
  logic        gap;
  logic        fair_sat;
  logic [31:0] hold_reg;
  logic [31:0] dma_rdata_q;

  // reset is folded in so the bus is pure pass-through while resetb is low
  assign steal = resetb && (state == CPU_OWN) && !gap && dma_req &&
                 mem_ready && !cpu_lock &&
                 ((cpu_trans == TRANS_IDLE) || fair_sat);

`ifdef YRV_ARB_FAIR_EN
  logic wdog_inc;
  logic wdog_clr;

  assign wdog_inc = (state == CPU_OWN) && dma_req && !steal;
  assign wdog_clr = steal || !dma_req;

  yrv_arb_wdog #(
    .WAIT_W   (WAIT_W),
    .WAIT_MAX (WAIT_MAX)
  ) u_wdog (
    .clk    (clk),
    .resetb (resetb),
    .inc    (wdog_inc),
    .clr    (wdog_clr),
    .sat    (fair_sat)
  );
`else
  // no counter: steals only on idle cpu slots; parameters kept for
  // drop-in compatibility of the port/parameter list
  assign fair_sat = (WAIT_MAX > WAIT_W) & 1'b0;
`endif

  // state, steal spacing, parked cpu read data and held secondary read data
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= CPU_OWN;
      gap         <= 1'b0;
      hold_reg    <= '0;
      dma_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      gap   <= (state == DMA_DATA) && mem_ready;
      if (steal)   hold_reg    <= mem_rdata;
      if (dma_ack) dma_rdata_q <= mem_rdata;
    end
  end

  // next state and bus/port muxing; defaults are the cpu pass-through
  always_comb begin
    state_nxt = state;
    phase     = steal ? DMA_ADDR : state;
    mem_addr  = cpu_addr;
    mem_trans = cpu_trans;
    mem_write = cpu_write;
    mem_lock  = cpu_lock;
    mem_ble   = cpu_ble;
    mem_wdata = cpu_wdata;
    cpu_ready = mem_ready;
    cpu_rdata = mem_rdata;
    dma_ack   = 1'b0;
    dma_rdata = dma_rdata_q;

    case (phase)
      CPU_OWN: begin
        state_nxt = CPU_OWN;
      end
      DMA_ADDR: begin
        // secondary address phase; the cpu's data phase is still on the bus
        state_nxt = DMA_DATA;
        mem_addr  = dma_addr;
        mem_trans = TRANS_DATA;
        mem_write = dma_write;
        mem_lock  = 1'b0;
        mem_ble   = dma_ble;
        cpu_ready = 1'b0;
      end
      DMA_DATA: begin
        // cpu re-issues its stalled address; secondary data phase completes
        mem_wdata = dma_wdata;
        cpu_rdata = hold_reg;
        if (mem_ready) begin
          state_nxt = CPU_OWN;
          dma_ack   = 1'b1;
          dma_rdata = mem_rdata;
        end
      end
      default: begin
        state_nxt = CPU_OWN;
      end
    endcase
  end

endmodule

// File: tb/tb_yrv_bus_arb.sv
// Self-checking bench for yrv_bus_arb: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_yrv_bus_arb;

  localparam int WAIT_MAX = 8;
`ifdef YRV_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        resetb;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_trans;
  logic        cpu_write;
  logic        cpu_lock;
  logic [3:0]  cpu_ble;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic        dma_write;
  logic [3:0]  dma_ble;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [1:0]  mem_trans;
  logic        mem_write;
  logic        mem_lock;
  logic [3:0]  mem_ble;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  yrv_bus_arb #(
    .WAIT_W   (4),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .cpu_addr  (cpu_addr),
    .cpu_trans (cpu_trans),
    .cpu_write (cpu_write),
    .cpu_lock  (cpu_lock),
    .cpu_ble   (cpu_ble),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_write (dma_write),
    .dma_ble   (dma_ble),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_trans (mem_trans),
    .mem_write (mem_write),
    .mem_lock  (mem_lock),
    .mem_ble   (mem_ble),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: is a secondary transfer in its data phase, cycles the
  // request has waited, whether the last cycle finished a secondary transfer,
  // the parked cpu read data and the last secondary read data
  bit          m_busy;
  int          m_wait;
  bit          m_gap;
  logic [31:0] m_hold;
  logic [31:0] m_last;
  bit          m_steal;

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_gap = 0; m_hold = '0; m_last = '0; m_steal = 0;
  endtask

  // settle inputs, then compare every output with the model's prediction
  task automatic cyc_check();
    logic [31:0] e_addr, e_wdata, e_crd, e_drd;
    logic [1:0]  e_trans;
    logic        e_write, e_lock, e_crdy, e_ack;
    logic [3:0]  e_ble;
    #2;
    if (!resetb) model_reset();
    m_steal = resetb && !m_busy && !m_gap && dma_req && mem_ready && !cpu_lock &&
              (cpu_trans == 2'b00 || (FAIR && m_wait >= WAIT_MAX));
    e_addr = cpu_addr; e_trans = cpu_trans; e_write = cpu_write; e_lock = cpu_lock;
    e_ble = cpu_ble; e_wdata = cpu_wdata; e_crdy = mem_ready; e_crd = mem_rdata;
    e_ack = 1'b0; e_drd = m_last;
    if (m_steal) begin
      e_addr = dma_addr; e_trans = 2'b10; e_write = dma_write; e_lock = 1'b0;
      e_ble = dma_ble; e_crdy = 1'b0;
    end else if (m_busy) begin
      e_wdata = dma_wdata; e_crd = m_hold;
      if (mem_ready) begin e_ack = 1'b1; e_drd = mem_rdata; end
    end
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_trans", mem_trans, e_trans);
    chk("mem_write", mem_write, e_write);
    chk("mem_lock", mem_lock, e_lock);
    chk("mem_ble", mem_ble, e_ble);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_ready", cpu_ready, e_crdy);
    if (e_crdy) chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dma_ack", dma_ack, e_ack);
    chk("dma_rdata", dma_rdata, e_drd);
  endtask

  // advance the model by the rules of one clock edge, then take the edge
  task automatic cyc_adv();
    if (resetb) begin
      if (m_steal) begin
        m_busy = 1; m_hold = mem_rdata; m_wait = 0;
      end else if (m_busy) begin
        if (!dma_req) m_wait = 0;
        if (mem_ready) begin m_busy = 0; m_last = mem_rdata; m_gap = 1; end
      end else begin
        m_gap = 0;
        if (!dma_req) m_wait = 0;
        else if (m_wait < WAIT_MAX) m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc_check();
    cyc_adv();
  endtask

  // let a pending request through on idle zero-wait slots
  task automatic drain();
    bit got;
    if (dma_req) begin
      got = 0;
      cpu_trans = 2'b00; cpu_lock = 1'b0; mem_ready = 1'b1;
      for (int k = 0; k < 6 && !got; k++) begin
        cyc_check();
        got = dma_ack;
        cyc_adv();
      end
      dma_req = 1'b0;
      chk("drain_ack", got, 1'b1);
    end
  endtask

  initial begin
    int          first;
    int          steals;
    int          nready;
    bit          ackp;
    bit          stole;

    resetb = 1'b0;
    cpu_addr = 32'h0; cpu_trans = 2'b00; cpu_write = 1'b0; cpu_lock = 1'b0;
    cpu_ble = 4'hF; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_addr = 32'h0; dma_write = 1'b0; dma_ble = 4'hF; dma_wdata = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    model_reset();
    #1;

    // reset: pass-through, no ack, cleared read data
    mem_rdata = 32'h1111_2222; cpu_addr = 32'h80;
    cyc_check();
    chk("rst_ack", dma_ack, 1'b0);
    chk("rst_drd", dma_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h80);
    cyc_adv();
    step();
    resetb = 1'b1;

    // zero-wait idle steal: grant same cycle, ack next cycle
    cpu_trans = 2'b00; cpu_addr = 32'h2000; mem_ready = 1'b1;
    dma_req = 1'b1; dma_addr = 32'h100; dma_write = 1'b0; dma_ble = 4'h3;
    cyc_check();
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_trans", mem_trans, 2'b10);
    chk("t1_cpu_ready", cpu_ready, 1'b0);
    cyc_adv();
    mem_rdata = 32'hDEAD_BEEF;
    cyc_check();
    chk("t1_ack", dma_ack, 1'b1);
    chk("t1_drd", dma_rdata, 32'hDEAD_BEEF);
    cyc_adv();
    dma_req = 1'b0; mem_rdata = 32'h0000_1234;
    cyc_check();
    chk("t1_ack_pulse", dma_ack, 1'b0);
    chk("t1_drd_hold", dma_rdata, 32'hDEAD_BEEF);
    cyc_adv();

    // busy cpu fetch stream: forced steal only with the counter
    first = -1; nready = 0; ackp = 0;
    cpu_trans = 2'b01; cpu_lock = 1'b0; mem_ready = 1'b1;
    dma_req = 1'b1; dma_addr = 32'h200; dma_ble = 4'hF;
    for (int i = 0; i < 100; i++) begin
      if (ackp) dma_req = 1'b0;
      cpu_addr  = 32'h1000 + 32'(4 * nready);
      mem_rdata = (i == 8) ? 32'hA5A5_A5A5 : 32'(i);
      cyc_check();
      if (first < 0 && cpu_ready == 1'b0) begin
        first = i;
        chk("t2_steal_ready", cpu_ready, 1'b0);
      end
      if (first == 8 && i == 9) begin
        chk("t2_replay", cpu_rdata, 32'hA5A5_A5A5);
        chk("t2_cpu_addr", mem_addr, 32'h0000_1020);
      end
      ackp = dma_ack;
      if (cpu_ready) nready++;
      cyc_adv();
    end
    chk("t2_first_steal", first, FAIR ? 8 : -1);
    drain();

    // cpu write data phase overlapping a steal
    cpu_trans = 2'b10; cpu_write = 1'b1; cpu_addr = 32'h3000; mem_ready = 1'b1;
    step();
    cpu_trans = 2'b00; cpu_write = 1'b0; cpu_wdata = 32'hC0FF_EE01;
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 32'h300; dma_wdata = 32'h0D0A_0D0A;
    cyc_check();
    chk("t3_wdata_addr", mem_wdata, 32'hC0FF_EE01);
    chk("t3_write", mem_write, 1'b1);
    cyc_adv();
    cyc_check();
    chk("t3_wdata_data", mem_wdata, 32'h0D0A_0D0A);
    chk("t3_ack", dma_ack, 1'b1);
    cyc_adv();
    dma_req = 1'b0; dma_write = 1'b0;
    step();

    // locked cpu blocks stealing even after the counter saturates
    steals = 0;
    cpu_lock = 1'b1; cpu_trans = 2'b10; mem_ready = 1'b1;
    dma_req = 1'b1; dma_addr = 32'h400;
    for (int i = 0; i < 12; i++) begin
      cyc_check();
      if (!cpu_ready) steals++;
      cyc_adv();
    end
    chk("t4_locked", steals, 0);
    cpu_lock = 1'b0;
    cyc_check();
    stole = !cpu_ready;
    chk("t4_release", stole, FAIR);
    cyc_adv();
    drain();
    step();

    // reset while a secondary data phase is waiting
    cpu_trans = 2'b00; mem_ready = 1'b1; dma_req = 1'b1; dma_addr = 32'h500;
    step();
    mem_ready = 1'b0; cpu_trans = 2'b01; cpu_addr = 32'h4444; cpu_wdata = 32'h5555_6666;
    dma_wdata = 32'h7777_8888;
    step();
    resetb = 1'b0;
    cyc_check();
    chk("t5_ack", dma_ack, 1'b0);
    chk("t5_addr", mem_addr, 32'h4444);
    chk("t5_wdata", mem_wdata, 32'h5555_6666);
    cyc_adv();
    mem_ready = 1'b1; mem_rdata = 32'h9999_0000;
    cyc_check();
    chk("t5_ack_rdy", dma_ack, 1'b0);
    chk("t5_ready", cpu_ready, 1'b1);
    cyc_adv();
    dma_req = 1'b0; resetb = 1'b1;
    cyc_check();
    chk("t5_drd", dma_rdata, 32'h0);
    cyc_adv();

    // randomized traffic against the model
    ackp = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ackp) dma_req = 1'($urandom_range(0, 1));
      if (ackp || !dma_req) begin
        if (!dma_req && $urandom_range(0, 3) == 0) dma_req = 1'b1;
        dma_addr  = $urandom;
        dma_write = 1'($urandom);
        dma_ble   = 4'($urandom);
        dma_wdata = $urandom;
      end
      cpu_addr  = $urandom;
      cpu_trans = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      cpu_write = 1'($urandom);
      cpu_lock  = ($urandom_range(0, 7) == 0);
      cpu_ble   = 4'($urandom);
      cpu_wdata = $urandom;
      mem_ready = ($urandom_range(0, 9) < 7);
      mem_rdata = $urandom;
      cyc_check();
      ackp = dma_ack;
      cyc_adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
